frogger_level_controller: RTL and testbench
===========================================

Name: frogger_level_controller

Overview:
Game-progression sequencer for Frogger. Owns the level counter whose value feeds the level comparator (game won when level reaches MAX_LEVEL), and tracks lives. Produces per-level car-speed reload values and board-clear pulses. Sits between the frog/collision logic and the car-movement and display blocks.

Parameters:
COUNTER_LEVELS_DATAWIDTH, 5, width of the level count.
MAX_LEVEL, 5, level value that declares the game won.
INIT_LIVES, 3, lives at game start (≤7).
PAUSE_CYCLES, 16, clock cycles spent in level-transition pause (≥1).
SPEED_BASE, 24'd5000000, car-step reload value at level 0.
SPEED_STEP, 24'd800000, reload reduction per level. Require SPEED_BASE > MAX_LEVEL*SPEED_STEP.

Ports:
frogger_level_controller_CLOCK_50  input  1  system clock.
frogger_level_controller_RESET_InHigh  input  1  synchronous active-high reset.
frogger_level_controller_start_InLow  input  1  start/restart request, active low, level-sensitive.
frogger_level_controller_goal_InHigh  input  1  one-cycle pulse: frog reached top row.
frogger_level_controller_hit_InHigh  input  1  one-cycle pulse: frog collided with a car.
frogger_level_controller_level_Out  output  COUNTER_LEVELS_DATAWIDTH  current level, 0-based.
frogger_level_controller_lives_Out  output  3  remaining lives.
frogger_level_controller_speed_Out  output  24  car-step reload value = SPEED_BASE − level*SPEED_STEP.
frogger_level_controller_run_OutHigh  output  1  high only in PLAY; gates car and frog movement.
frogger_level_controller_clear_OutHigh  output  1  one-cycle pulse: respawn frog / reset board.
frogger_level_controller_win_OutLow  output  1  low in WIN state.
frogger_level_controller_over_OutLow  output  1  low in LOSE state.

Behaviour:
- All state registered on rising CLOCK_50. Reset is synchronous and active-high; when asserted it overrides all inputs.
- Reset values: state IDLE, level 0, lives INIT_LIVES, speed SPEED_BASE, run 0, clear 0, win_OutLow 1, over_OutLow 1, pause counter 0.
- States: IDLE, PLAY, PAUSE, WIN, LOSE.
- IDLE:
  - start_InLow=0 → PLAY next cycle. Level is set to 0 and lives to INIT_LIVES.
  - clear pulses for 1 cycle on the transition.
- PLAY: run=1.
  - goal=1 and level+1 == MAX_LEVEL → WIN. Level becomes MAX_LEVEL.
  - goal=1 otherwise → PAUSE. Level increments by 1 and pause counter loads PAUSE_CYCLES−1.
  - hit=1 and lives==1 → LOSE. Lives becomes 0.
  - hit=1 and lives>1 → PAUSE. Lives decrements and level is unchanged.
  - goal and hit in the same cycle: hit has priority. Goal is ignored.
- PAUSE: run=0. Goal/hit pulses are ignored.
  - Counter decrements each cycle.
  - When counter==0 → PLAY, with clear pulsing 1 cycle on that transition.
  - Total PAUSE dwell is exactly PAUSE_CYCLES cycles.
- WIN: win_OutLow=0 and run=0. Holds until start_InLow=0, then → IDLE.
- LOSE: over_OutLow=0 and run=0. Holds until start_InLow=0, then → IDLE.
- Restart path: leaving WIN/LOSE goes to IDLE. If start is still held low, IDLE → PLAY on the following cycle. A held start therefore restarts after 2 cycles.
- speed_Out is registered from level and updates in the same cycle as level. It never wraps, because level ≤ MAX_LEVEL.
- Level never exceeds MAX_LEVEL; lives never underflow.
- Reset asserted mid-PAUSE or mid-PLAY returns to reset values on the next edge, with no clear pulse.

Test Plan:
- Reset, then start_InLow=0 for 1 cycle → IDLE→PLAY, clear=1 for one cycle, level=0, lives=3, speed=5000000, run=1.
- In PLAY, pulse goal → next cycle level=1, speed=4200000, run=0. Exactly 16 cycles later run=1 and clear pulses once.
- Drive 5 goals with pauses in between → after the 5th, level=5, win_OutLow=0, run=0. Further goal pulses leave the outputs unchanged.
- From level 2, pulse hit three times (waiting out each pause) → lives 2, 1, 0; after the third hit over_OutLow=0 and level stays 2.
- Goal and hit on the same cycle at lives=3, level=0 → lives=2, level=0, PAUSE entered.
- In PAUSE with 8 cycles left, assert RESET_InHigh for 1 cycle → next edge: IDLE, level 0, lives 3, run 0, no clear pulse. In LOSE, hold start low → IDLE, then PLAY with lives=3.

Source files
------------

// File: rtl/frogger_level_controller.sv
// Frogger level/lives sequencer.
// Drives car speed, board clear, and the win/lose flags.
module frogger_level_controller #(
  parameter int          COUNTER_LEVELS_DATAWIDTH = 5,
  parameter int          MAX_LEVEL    = 5,
  parameter int          INIT_LIVES   = 3,
  parameter int          PAUSE_CYCLES = 16,
  parameter logic [23:0] SPEED_BASE   = 24'd5000000,
  parameter logic [23:0] SPEED_STEP   = 24'd800000
) (
  input  logic frogger_level_controller_CLOCK_50,
  input  logic frogger_level_controller_RESET_InHigh,
  input  logic frogger_level_controller_start_InLow,
  input  logic frogger_level_controller_goal_InHigh,
  input  logic frogger_level_controller_hit_InHigh,
  output logic [COUNTER_LEVELS_DATAWIDTH-1:0]
               frogger_level_controller_level_Out,
  output logic [2:0]  frogger_level_controller_lives_Out,
  output logic [23:0] frogger_level_controller_speed_Out,
  output logic frogger_level_controller_run_OutHigh,
  output logic frogger_level_controller_clear_OutHigh,
  output logic frogger_level_controller_win_OutLow,
  output logic frogger_level_controller_over_OutLow
);

  localparam int LW = COUNTER_LEVELS_DATAWIDTH;
  localparam int PW = $clog2(PAUSE_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, PLAY, PAUSE, WIN, LOSE
  } state_t;

  state_t stateQ, stateD;
  logic [LW-1:0] levelQ, levelD;
  logic [2:0]    livesQ, livesD;
  logic [PW-1:0] cntQ, cntD;
  logic [23:0]   speedQ, speedD;
  logic          runQ, clearQ, winQ, overQ;
  logic          clearD;

  wire clk   = frogger_level_controller_CLOCK_50;
  wire rst   = frogger_level_controller_RESET_InHigh;
  wire start = ~frogger_level_controller_start_InLow;
  wire goal  = frogger_level_controller_goal_InHigh;
  wire hit   = frogger_level_controller_hit_InHigh;

  always_comb begin
    stateD = stateQ;
    levelD = levelQ;
    livesD = livesQ;
    cntD   = cntQ;
    clearD = 1'b0;
    unique case (stateQ)
      IDLE: begin
        if (start) begin
          stateD = PLAY;
          levelD = '0;
          livesD = 3'(INIT_LIVES);
          clearD = 1'b1;
        end
      end
      PLAY: begin
        // a collision outranks reaching the goal
        if (hit) begin
          if (livesQ <= 3'd1) begin
            stateD = LOSE;
            livesD = 3'd0;
          end else begin
            stateD = PAUSE;
            livesD = livesQ - 3'd1;
            cntD   = PW'(PAUSE_CYCLES - 1);
          end
        end else if (goal) begin
          if (levelQ == LW'(MAX_LEVEL - 1)) begin
            stateD = WIN;
            levelD = LW'(MAX_LEVEL);
          end else begin
            stateD = PAUSE;
            levelD = levelQ + LW'(1);
            cntD   = PW'(PAUSE_CYCLES - 1);
          end
        end
      end
      PAUSE: begin
        if (cntQ == '0) begin
          stateD = PLAY;
          clearD = 1'b1;
        end else begin
          cntD = cntQ - PW'(1);
        end
      end
      WIN, LOSE: begin
        if (start) stateD = IDLE;
      end
      default: stateD = IDLE;
    endcase
  end

  assign speedD = SPEED_BASE - 24'(levelD) * SPEED_STEP;

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= IDLE;
      levelQ <= '0;
      livesQ <= 3'(INIT_LIVES);
      cntQ   <= '0;
      speedQ <= SPEED_BASE;
      runQ   <= 1'b0;
      clearQ <= 1'b0;
      winQ   <= 1'b1;
      overQ  <= 1'b1;
    end else begin
      stateQ <= stateD;
      levelQ <= levelD;
      livesQ <= livesD;
      cntQ   <= cntD;
      speedQ <= speedD;
      runQ   <= (stateD == PLAY);
      clearQ <= clearD;
      winQ   <= (stateD != WIN);
      overQ  <= (stateD != LOSE);
    end
  end

  assign frogger_level_controller_level_Out  = levelQ;
  assign frogger_level_controller_lives_Out  = livesQ;
  assign frogger_level_controller_speed_Out  = speedQ;
  assign frogger_level_controller_run_OutHigh   = runQ;
  assign frogger_level_controller_clear_OutHigh = clearQ;
  assign frogger_level_controller_win_OutLow    = winQ;
  assign frogger_level_controller_over_OutLow   = overQ;

endmodule

// File: tb/tb_frogger_level_controller.sv
// Directed bench for frogger_level_controller.
// Expected snapshots are queued per step and popped after the edge.
module tb_frogger_level_controller;

  logic clk = 1'b0;
  logic rst, startN, goal, hit;
  logic [4:0]  level;
  logic [2:0]  lives;
  logic [23:0] speed;
  logic run, clear, winN, overN;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [4:0]  lvl;
    logic [2:0]  lives;
    logic [23:0] speed;
    logic        run;
    logic        clr;
    logic        win;
    logic        over;
  } exp_t;

  exp_t sb[$];

  always #10 clk = ~clk;

  frogger_level_controller dut (
    .frogger_level_controller_CLOCK_50(clk),
    .frogger_level_controller_RESET_InHigh(rst),
    .frogger_level_controller_start_InLow(startN),
    .frogger_level_controller_goal_InHigh(goal),
    .frogger_level_controller_hit_InHigh(hit),
    .frogger_level_controller_level_Out(level),
    .frogger_level_controller_lives_Out(lives),
    .frogger_level_controller_speed_Out(speed),
    .frogger_level_controller_run_OutHigh(run),
    .frogger_level_controller_clear_OutHigh(clear),
    .frogger_level_controller_win_OutLow(winN),
    .frogger_level_controller_over_OutLow(overN)
  );

  function automatic logic [23:0] spd(input int l);
    return 24'(5000000 - l * 800000);
  endfunction

  task automatic push(input int l, input int lv,
                      input logic r, input logic c,
                      input logic w, input logic o);
    exp_t e;
    e.lvl   = 5'(l);
    e.lives = 3'(lv);
    e.speed = spd(l);
    e.run   = r;
    e.clr   = c;
    e.win   = w;
    e.over  = o;
    sb.push_back(e);
  endtask

  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    total++;
    assert (sb.size() > 0) else begin
      bad++;
      $error("FAIL %s: scoreboard empty", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      assert (level === e.lvl) else begin
        bad++;
        $error("FAIL %s level: got %0d want %0d", tag, level, e.lvl);
      end
      total++;
      assert (lives === e.lives) else begin
        bad++;
        $error("FAIL %s lives: got %0d want %0d", tag, lives, e.lives);
      end
      total++;
      assert (speed === e.speed) else begin
        bad++;
        $error("FAIL %s speed: got %0d want %0d", tag, speed, e.speed);
      end
      total++;
      assert (run === e.run) else begin
        bad++;
        $error("FAIL %s run: got %b want %b", tag, run, e.run);
      end
      total++;
      assert (clear === e.clr) else begin
        bad++;
        $error("FAIL %s clear: got %b want %b", tag, clear, e.clr);
      end
      total++;
      assert (winN === e.win) else begin
        bad++;
        $error("FAIL %s win: got %b want %b", tag, winN, e.win);
      end
      total++;
      assert (overN === e.over) else begin
        bad++;
        $error("FAIL %s over: got %b want %b", tag, overN, e.over);
      end
    end
  endtask

  task automatic step(input string tag, input int l,
                      input int lv, input logic r,
                      input logic c, input logic w,
                      input logic o);
    push(l, lv, r, c, w, o);
    tick(tag);
  endtask

  // after the entry edge: 15 more paused cycles, then resume
  task automatic waitPause(input string tag, input int l,
                           input int lv);
    repeat (15) step({tag, "_pause"}, l, lv, 0, 0, 1, 1);
    step({tag, "_resume"}, l, lv, 1, 1, 1, 1);
  endtask

  task automatic pulseGoal(input string tag, input int l,
                           input int lv);
    goal = 1'b1;
    step({tag, "_goal"}, l, lv, 0, 0, 1, 1);
    goal = 1'b0;
    waitPause(tag, l, lv);
  endtask

  task automatic pulseHit(input string tag, input int l,
                          input int lv);
    hit = 1'b1;
    step({tag, "_hit"}, l, lv, 0, 0, 1, 1);
    hit = 1'b0;
    waitPause(tag, l, lv);
  endtask

  initial begin
    rst = 1'b1; startN = 1'b1; goal = 1'b0; hit = 1'b0;
    step("reset", 0, 3, 0, 0, 1, 1);
    rst = 1'b0;
    step("idle", 0, 3, 0, 0, 1, 1);

    startN = 1'b0;
    step("start", 0, 3, 1, 1, 1, 1);
    startN = 1'b1;
    step("play0", 0, 3, 1, 0, 1, 1);

    goal = 1'b1;
    step("goal1", 1, 3, 0, 0, 1, 1);
    goal = 1'b0;
    repeat (4) step("p1", 1, 3, 0, 0, 1, 1);
    goal = 1'b1; hit = 1'b1;
    step("p1_ign", 1, 3, 0, 0, 1, 1);
    goal = 1'b0; hit = 1'b0;
    repeat (10) step("p1", 1, 3, 0, 0, 1, 1);
    step("p1_resume", 1, 3, 1, 1, 1, 1);
    step("play1", 1, 3, 1, 0, 1, 1);

    goal = 1'b1;
    step("goal2", 2, 3, 0, 0, 1, 1);
    goal = 1'b0;
    waitPause("l2", 2, 3);
    pulseGoal("l3", 3, 3);
    pulseGoal("l4", 4, 3);

    goal = 1'b1;
    step("win", 5, 3, 0, 0, 0, 1);
    step("win_goal", 5, 3, 0, 0, 0, 1);
    goal = 1'b0;
    step("win_hold", 5, 3, 0, 0, 0, 1);

    startN = 1'b0;
    step("win_idle", 5, 3, 0, 0, 1, 1);
    step("restart1", 0, 3, 1, 1, 1, 1);
    startN = 1'b1;

    pulseGoal("h1", 1, 3);
    pulseGoal("h2", 2, 3);
    pulseHit("hit1", 2, 2);
    pulseHit("hit2", 2, 1);
    hit = 1'b1;
    step("lose", 2, 0, 0, 0, 1, 0);
    hit = 1'b0;
    step("lose_hold", 2, 0, 0, 0, 1, 0);

    startN = 1'b0;
    step("lose_idle", 2, 0, 0, 0, 1, 1);
    step("restart2", 0, 3, 1, 1, 1, 1);
    startN = 1'b1;
    step("play_r2", 0, 3, 1, 0, 1, 1);

    goal = 1'b1; hit = 1'b1;
    step("both", 0, 2, 0, 0, 1, 1);
    goal = 1'b0; hit = 1'b0;
    repeat (7) step("bp", 0, 2, 0, 0, 1, 1);
    rst = 1'b1;
    step("rst_pause", 0, 3, 0, 0, 1, 1);
    rst = 1'b0;
    step("post_rst", 0, 3, 0, 0, 1, 1);
    step("post_rst2", 0, 3, 0, 0, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
